uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver. It is the next generation of the team's fixed 8N1 receiver, adding:
- configurable data width, parity and stop-bit count
- start-bit validation and framing/parity error flags
- a valid/ready output holding register with overrun detection

It sits between the board RX pin and the command/data deserialiser feeding the SM4/Picnic core.

Parameters:
SYS_CLK_FRE, 100_000_000, system clock frequency in Hz.
BPS, 115200, baud rate. Derived: BPS_CNT = SYS_CLK_FRE/BPS; HALF = BPS_CNT/2.
DATA_BITS, 8, data bits per frame. Legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk.
rx_ready  input  1  consumer accepts the held word when rx_valid=1.
rx_valid  output  1  held word available.
rx_data  output  DATA_BITS  received word, LSB = first bit on the line.
rx_parity_err  output  1  parity mismatch for the held word (always 0 when PARITY=0).
rx_frame_err  output  1  a stop bit sampled 0 for the held word.
rx_overrun  output  1  one-cycle pulse: a completed frame was dropped.
rx_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset:
  - 2-FF synchroniser resets to 1 (line idle), so no false start is detected on reset release.
  - All outputs reset to 0. FSM resets to IDLE. Counters reset to 0.
  - Reset mid-frame aborts the frame; no output is produced.
- Counters:
  - Baud counter clk_cnt, width $clog2(BPS_CNT). It counts 0..BPS_CNT-1 and wraps.
  - Bit counter is wide enough for DATA_BITS.
- Start detection: falling edge on the synchronised line (d1=1, d0=0) while in IDLE moves to START and clears clk_cnt.
- START: at clk_cnt==HALF the line is sampled.
  - Sample 1: false start; return to IDLE, no output.
  - Sample 0: continue; the next bit is centred BPS_CNT cycles later.
- DATA:
  - DATA_BITS samples, LSB first, each taken at mid-bit (clk_cnt==HALF).
  - Shifted into the shift register at bit index.
- PARITY (only if PARITY!=0): one sample.
  - Expected value: odd mode makes XOR(data, parity bit)=1; even mode makes it 0.
  - A mismatch sets the internal perr.
- STOP: STOP_BITS samples; any 0 sets the internal ferr.
- Frame completion: at the mid-bit sample of the last stop bit.
  - The FSM returns to IDLE on the same edge, so a start edge arriving 0.5 bit later is caught.
  - On the following edge (latency 1 cycle after the final sample) the holding register loads data/perr/ferr and rx_valid goes to 1.
- Handshake:
  - rx_valid stays high and rx_data/err flags stay stable until a cycle with rx_valid&&rx_ready.
  - rx_valid clears on the next edge unless a new frame loads in that same cycle.
- Simultaneous accept and completion: the new frame loads, rx_valid stays 1, no overrun.
- Completion while rx_valid=1 and rx_ready=0:
  - The new frame is discarded; the old word is kept.
  - rx_overrun pulses high for exactly one cycle.
- Frames with errors are still delivered; the flags qualify rx_data.
- Line held low (break): ferr is set, then the receiver waits in IDLE for the line to return high before a new falling edge can start a frame.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: every sample (start, data, parity, stop) is the 2-of-3 majority of the synchronised line at clk_cnt==HALF-1, HALF and HALF+1. The decision is used at HALF+1, so per-bit timing shifts by 1 cycle; total latency is +1 cycle.
- Undefined: single sample at clk_cnt==HALF.

Test Plan:
1. Defaults (BPS_CNT=868). Send 8N1 0xA5, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5, both error flags 0. rx_valid rises 1 cycle after the stop-bit mid-sample.
2. PARITY=2, send 0x3C with the parity bit=1 (wrong) → rx_data=0x3C, rx_parity_err=1. Resend with correct parity 0 → rx_parity_err=0.
3. Send 0x55 with stop bit=0 → rx_frame_err=1, rx_data=0x55. The next good frame 0x12 is received correctly.
4. rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11 and rx_overrun pulses 1 cycle at the second completion. Raising rx_ready → accepts 0x11, then rx_valid=0.
5. Glitch: line low for 200 cycles (< HALF) → no rx_valid, rx_busy returns to 0. Apply sys_rst_n low mid-frame → all outputs 0, next frame 0x7E is received correctly.
6. DATA_BITS=9, STOP_BITS=2, send 0x1A5 → rx_data=0x1A5. With UART_RX_MAJORITY_VOTE_EN, a 1-cycle glitch at HALF on bit 3 → rx_data unchanged.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Output handshake of uart_rx_cfg: held word, its error flags and the overrun pulse.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_ready;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    input  rx_ready,
    output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    output rx_ready,
    input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver (data width, parity, stop bits) with a valid/ready holding register.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_cfg #(
  parameter int unsigned SYS_CLK_FRE = 100_000_000,
  parameter int unsigned BPS         = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          uart_rxd,
  output logic          rx_busy,
  uart_rx_cfg_if.master rx
);

  localparam int unsigned BPS_CNT = SYS_CLK_FRE / BPS;
  localparam int unsigned HALF    = BPS_CNT / 2;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic                 rxd_meta, rxd_sync, rxd_prev;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 done, done_n;
  logic                 fall_c;
  logic                 sample_tick_c;
  logic                 sample_bit_c;

  // Two-flop synchroniser; reset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall_c = rxd_prev & ~rxd_sync;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] win;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win <= 2'b11;
    end else begin
      win <= {win[0], rxd_sync};
    end
  end

  // win holds the line at HALF-1 and HALF when the counter reads HALF+1.
  assign sample_tick_c = (clk_cnt == CNT_W'(HALF + 1));
  assign sample_bit_c  = (win[1] & win[0]) | (win[1] & rxd_sync) | (win[0] & rxd_sync);
`else
  assign sample_tick_c = (clk_cnt == CNT_W'(HALF));
  assign sample_bit_c  = rxd_sync;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      done    <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      done    <= done_n;
      rx_busy <= (state_n != S_IDLE);
    end
  end

  // Frame sequencing: one decision per bit at the mid-bit sample tick.
  always_comb begin
    state_n   = state;
    clk_cnt_n = (clk_cnt == CNT_W'(BPS_CNT - 1)) ? '0 : clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    perr_n    = perr;
    ferr_n    = ferr;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        if (fall_c) begin
          state_n = S_START;
        end
      end
      S_START: begin
        if (sample_tick_c) begin
          if (sample_bit_c) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
            perr_n    = 1'b0;
            ferr_n    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample_tick_c) begin
          shift_n[bit_cnt] = sample_bit_c;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_tick_c) begin
          perr_n  = (^shift) ^ sample_bit_c ^ (PARITY == 1);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_tick_c) begin
          if (!sample_bit_c) begin
            ferr_n = 1'b1;
          end
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_n = '0;
            done_n    = 1'b1;
            state_n   = S_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Holding register: a completed frame loads only if the slot is free or being accepted now.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx.rx_valid      <= 1'b0;
      rx.rx_data       <= '0;
      rx.rx_parity_err <= 1'b0;
      rx.rx_frame_err  <= 1'b0;
      rx.rx_overrun    <= 1'b0;
    end else begin
      rx.rx_overrun <= 1'b0;
      if (done) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_valid      <= 1'b1;
          rx.rx_data       <= shift;
          rx.rx_parity_err <= perr;
          rx.rx_frame_err  <= ferr;
        end else begin
          rx.rx_overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations driven by directed frames, checked every cycle
// against a frame-level model of completion time, handshake and overrun.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int unsigned SYS     = 3_200_000;
  localparam int unsigned BAUD    = 100_000;
  localparam int          BPS_CNT = 32;
  localparam int          HALF    = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int          MV      = 1;
`else
  localparam int          MV      = 0;
`endif

  typedef struct {
    int         sel;
    longint     bstart;
    longint     bend;
    bit         deliver;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } fr_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   line [3];
  logic   rdy [3];
  logic   busy [3];
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  fr_t        pend[$];
  logic       m_valid [3];
  logic [8:0] m_data [3];
  logic       m_pe [3];
  logic       m_fe [3];
  logic       prev_rdy [3];
  logic       prev_v [3];
  bit         busy_chk [3];
  longint     last_rise [3];
  logic [8:0] last_data [3];
  logic       last_pe [3];
  logic       last_fe [3];
  int         ov_cnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if2 ();
  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign if2.rx_ready = rdy[2];

  uart_rx_cfg #(.SYS_CLK_FRE(SYS), .BPS(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(line[0]), .rx_busy(busy[0]), .rx(if0));
  uart_rx_cfg #(.SYS_CLK_FRE(SYS), .BPS(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(line[1]), .rx_busy(busy[1]), .rx(if1));
  uart_rx_cfg #(.SYS_CLK_FRE(SYS), .BPS(BAUD), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(line[2]), .rx_busy(busy[2]), .rx(if2));

  function automatic int nd(input int s); return (s == 2) ? 9 : 8; endfunction
  function automatic int np(input int s); return (s == 1) ? 2 : 0; endfunction
  function automatic int ns(input int s); return (s == 2) ? 2 : 1; endfunction

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", name, s, act, exp, cyc);
    end
  endtask

  // One cycle of the model for configuration s, then compare.
  task automatic step(input int s, input logic v, input logic [8:0] d, input logic pe,
                      input logic fe, input logic ov, input logic bsy);
    logic eov, ebusy;
    int   hit;
    if (!rst_n) begin
      m_valid[s] = 1'b0;
      prev_v[s]  = 1'b0;
      chk("reset_outputs", s, {17'd0, v, pe, fe, ov, bsy, d}, 32'd0);
    end else begin
      eov = 1'b0;
      hit = -1;
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].sel == s && pend[i].deliver && pend[i].bend + 1 == cyc) hit = i;
      if (hit >= 0) begin
        if (!m_valid[s] || prev_rdy[s]) begin
          m_valid[s] = 1'b1;
          m_data[s]  = pend[hit].data;
          m_pe[s]    = pend[hit].pe;
          m_fe[s]    = pend[hit].fe;
        end else begin
          eov = 1'b1;
        end
        pend.delete(hit);
      end else if (m_valid[s] && prev_rdy[s]) begin
        m_valid[s] = 1'b0;
      end
      ebusy = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].sel == s) begin
          if (!pend[i].deliver && cyc >= pend[i].bend) pend.delete(i);
          else if (cyc >= pend[i].bstart && cyc < pend[i].bend) ebusy = 1'b1;
        end
      end
      chk("rx_valid", s, {31'd0, v}, {31'd0, m_valid[s]});
      if (m_valid[s]) begin
        chk("rx_data", s, {23'd0, d}, {23'd0, m_data[s]});
        chk("rx_parity_err", s, {31'd0, pe}, {31'd0, m_pe[s]});
        chk("rx_frame_err", s, {31'd0, fe}, {31'd0, m_fe[s]});
      end
      chk("rx_overrun", s, {31'd0, ov}, {31'd0, eov});
      if (busy_chk[s]) chk("rx_busy", s, {31'd0, bsy}, {31'd0, ebusy});
      if (v && !prev_v[s]) begin
        last_rise[s] = cyc;
        last_data[s] = d;
        last_pe[s]   = pe;
        last_fe[s]   = fe;
      end
      if (ov) ov_cnt[s]++;
      prev_v[s] = v;
    end
    prev_rdy[s] = rdy[s];
  endtask

  always @(negedge clk) begin
    step(0, if0.rx_valid, {1'b0, if0.rx_data}, if0.rx_parity_err, if0.rx_frame_err, if0.rx_overrun, busy[0]);
    step(1, if1.rx_valid, {1'b0, if1.rx_data}, if1.rx_parity_err, if1.rx_frame_err, if1.rx_overrun, busy[1]);
    step(2, if2.rx_valid, if2.rx_data, if2.rx_parity_err, if2.rx_frame_err, if2.rx_overrun, busy[2]);
  end

  // Serialise one frame onto line[s]; expected outcome is queued for the compare process.
  task automatic send(input int s, input logic [8:0] data, input bit bad_par, input logic [1:0] stops,
                      input int glitch_bit, input bit keep_low, output longint t0);
    logic       bits [16];
    logic [8:0] mask, dm;
    int         n;
    fr_t        f;
    mask = 9'((10'd1 << nd(s)) - 10'd1);
    dm   = data & mask;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < nd(s); i++) bits[n++] = dm[i];
    if (np(s) != 0) bits[n++] = (^dm) ^ (np(s) == 1) ^ bad_par;
    bits[n++] = stops[0];
    if (ns(s) == 2) bits[n++] = stops[1];
    @(posedge clk);
    #1;
    t0 = cyc;
    f.sel     = s;
    f.bstart  = t0 + 3;
    f.bend    = t0 + HALF + 4 + longint'(n - 1) * BPS_CNT + MV;
    f.deliver = 1'b1;
    f.data    = dm;
    f.pe      = bad_par && (np(s) != 0);
    f.fe      = !stops[0] || (ns(s) == 2 && !stops[1]);
    pend.push_back(f);
    for (int j = 0; j < n; j++) begin
      line[s] = bits[j];
      if (j == glitch_bit) begin
        repeat (HALF + 1) @(posedge clk);
        #1 line[s] = ~bits[j];
        @(posedge clk);
        #1 line[s] = bits[j];
        repeat (BPS_CNT - HALF - 2) @(posedge clk);
      end else begin
        repeat (BPS_CNT) @(posedge clk);
      end
      #1;
    end
    if (!keep_low) line[s] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    longint t0;
    int     ov0;
    for (int s = 0; s < 3; s++) begin
      line[s] = 1'b1; rdy[s] = 1'b1; busy_chk[s] = 1'b1;
      prev_rdy[s] = 1'b1; prev_v[s] = 1'b0; m_valid[s] = 1'b0; ov_cnt[s] = 0;
      last_rise[s] = 0; last_data[s] = '0; last_pe[s] = 1'b0; last_fe[s] = 1'b0;
    end
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(2 * BPS_CNT);

    // 8N1 0xA5, consumer always ready
    send(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("latency_8n1", 0, 32'(last_rise[0] - t0), 32'(309 + MV));
    chk("data_a5", 0, {23'd0, last_data[0]}, 32'h0A5);
    chk("flags_a5", 0, {30'd0, last_pe[0], last_fe[0]}, 32'd0);
    idle(BPS_CNT);

    // Even parity: wrong then correct parity bit
    send(1, 9'h03C, 1'b1, 2'b11, -1, 1'b0, t0);
    chk("latency_8e1", 1, 32'(last_rise[1] - t0), 32'(341 + MV));
    chk("perr_bad", 1, {31'd0, last_pe[1]}, 32'd1);
    chk("data_3c", 1, {23'd0, last_data[1]}, 32'h03C);
    idle(BPS_CNT);
    send(1, 9'h03C, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("perr_good", 1, {31'd0, last_pe[1]}, 32'd0);
    idle(BPS_CNT);

    // Stop bit low, then a clean frame
    send(0, 9'h055, 1'b0, 2'b10, -1, 1'b0, t0);
    chk("ferr_55", 0, {31'd0, last_fe[0]}, 32'd1);
    chk("data_55", 0, {23'd0, last_data[0]}, 32'h055);
    idle(2 * BPS_CNT);
    send(0, 9'h012, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("data_12", 0, {23'd0, last_data[0]}, 32'h012);
    chk("ferr_12", 0, {31'd0, last_fe[0]}, 32'd0);
    idle(BPS_CNT);

    // Overrun: consumer stalled across two back-to-back frames
    rdy[0] = 1'b0;
    ov0 = ov_cnt[0];
    send(0, 9'h011, 1'b0, 2'b11, -1, 1'b0, t0);
    send(0, 9'h022, 1'b0, 2'b11, -1, 1'b0, t0);
    idle(4);
    chk("overrun_pulses", 0, 32'(ov_cnt[0] - ov0), 32'd1);
    chk("held_11", 0, {23'd0, 1'b0, if0.rx_data}, 32'h011);
    chk("held_valid", 0, {31'd0, if0.rx_valid}, 32'd1);
    rdy[0] = 1'b1;
    idle(2);
    chk("accepted", 0, {31'd0, if0.rx_valid}, 32'd0);
    idle(BPS_CNT);

    // Short low glitch: false start
    @(posedge clk);
    #1;
    t0 = cyc;
    pend.push_back('{sel: 0, bstart: t0 + 3, bend: t0 + HALF + 4 + MV, deliver: 1'b0,
                     data: 9'd0, pe: 1'b0, fe: 1'b0});
    line[0] = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    #1 line[0] = 1'b1;
    idle(3 * BPS_CNT);
    chk("glitch_busy", 0, {31'd0, busy[0]}, 32'd0);
    chk("glitch_valid", 0, {31'd0, if0.rx_valid}, 32'd0);

    // Reset in the middle of a frame
    busy_chk[0] = 1'b0;
    line[0] = 1'b0;
    idle(3 * BPS_CNT);
    chk("busy_mid", 0, {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    line[0] = 1'b1;
    idle(5);
    rst_n = 1'b1;
    busy_chk[0] = 1'b1;
    idle(2 * BPS_CNT);
    send(0, 9'h07E, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("data_7e", 0, {23'd0, last_data[0]}, 32'h07E);
    idle(BPS_CNT);

    // Break: line stays low after the frame; no restart until it returns high
    send(0, 9'h000, 1'b0, 2'b10, -1, 1'b1, t0);
    idle(3 * BPS_CNT);
    chk("break_ferr", 0, {31'd0, last_fe[0]}, 32'd1);
    chk("break_busy", 0, {31'd0, busy[0]}, 32'd0);
    line[0] = 1'b1;
    idle(2 * BPS_CNT);
    send(0, 9'h03A, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("data_3a", 0, {23'd0, last_data[0]}, 32'h03A);
    idle(BPS_CNT);

    // 9 data bits, 2 stop bits
    send(2, 9'h1A5, 1'b0, 2'b11, -1, 1'b0, t0);
    chk("latency_9n2", 2, 32'(last_rise[2] - t0), 32'(373 + MV));
    chk("data_1a5", 2, {23'd0, last_data[2]}, 32'h1A5);
    idle(BPS_CNT);
    send(2, 9'h0C3, 1'b0, 2'b01, -1, 1'b0, t0);
    chk("ferr_2nd_stop", 2, {31'd0, last_fe[2]}, 32'd1);
    idle(2 * BPS_CNT);
`ifdef UART_RX_MAJORITY_VOTE_EN
    send(2, 9'h1A5, 1'b0, 2'b11, 4, 1'b0, t0);
    chk("vote_glitch", 2, {23'd0, last_data[2]}, 32'h1A5);
    idle(BPS_CNT);
`endif

    idle(2 * BPS_CNT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
